// File: rtl/fb_pixel_writer.sv
// fb_pixel_writer
//   Write side of the frame buffer. It accepts rasterized pixels on a
//   valid/ready stream and converts each one to a byte address in the target
//   buffer. The pixels are queued in a small FIFO and drained as single-word
//   Avalon-MM writes. A flush handshake tells the renderer when every accepted
//   pixel is in memory, so it can swap buffers.
//
// Ports
//   clk                 system clock
//   reset               asynchronous, active-low reset
//   frame_buffer_ptr    byte base address of the target buffer (26 bits)
//   pix_valid/pix_ready pixel stream handshake
//   pix_x, pix_y        pixel column (10 bits) and row (9 bits)
//   pix_color           32-bit ARGB pixel word, written unmodified
//   flush               1-cycle pulse: drain all accepted pixels
//   flush_done          1-cycle pulse: the last write of the flush has completed
//   busy                FIFO non-empty, write in flight, or flush pending
//   drop_count          saturating count of out-of-range pixels discarded
//   master_*            Avalon-MM write-only master (address, write, writedata,
//                       waitrequest)
module fb_pixel_writer #(
  parameter int H_RES      = 640,
  parameter int V_RES      = 480,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [25:0] frame_buffer_ptr,
  input  logic        pix_valid,
  output logic        pix_ready,
  input  logic [9:0]  pix_x,
  input  logic [8:0]  pix_y,
  input  logic [31:0] pix_color,
  input  logic        flush,
  output logic        flush_done,
  output logic        busy,
  output logic [15:0] drop_count,
  output logic [25:0] master_address,
  output logic        master_write,
  output logic [31:0] master_writedata,
  input  logic        master_waitrequest
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

  state_t            state_reg, state_next;
  logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0]  count_reg;
  logic              flush_pending_reg;
  logic [15:0]       drop_count_reg;
  logic [25:0]       addr_reg;
  logic [31:0]       data_reg;

  // Each entry holds {byte address, colour}.
  logic [57:0]       fifo_mem [FIFO_DEPTH];

  logic        fifo_full, fifo_empty;
  logic        accept, in_range, accept_ok;
  logic        push, pop, bypass, clr_flush;
  logic [25:0] pix_offset, pix_addr;
  logic [57:0] head;

  assign fifo_full  = (count_reg == CNT_W'(FIFO_DEPTH));
  assign fifo_empty = (count_reg == '0);

  // Ready is derived from registered state only, so a pop in the same
  // cycle never opens a slot for a push while the FIFO is full.
  assign pix_ready = !fifo_full && !flush_pending_reg;
  assign accept    = pix_valid && pix_ready;
  assign in_range  = (32'(pix_x) < 32'(H_RES)) && (32'(pix_y) < 32'(V_RES));
  assign accept_ok = accept && in_range;

  // The offset is at most ~1.2 MB for in-range pixels. Truncating the sum to
  // 26 bits makes the address wrap modulo 2^26.
  assign pix_offset = 26'((32'(pix_y) * 32'(H_RES) + 32'(pix_x)) << 2);
  assign pix_addr   = frame_buffer_ptr + pix_offset;

  assign head = fifo_mem[rd_ptr_reg];

  // A pixel goes straight to the output registers when the FSM is idle and
  // nothing is queued. This gives a write in the cycle after acceptance.
  // Any other in-range pixel is queued.
  assign push = accept_ok && !bypass;

  always_comb begin
    state_next = state_reg;
    pop        = 1'b0;
    bypass     = 1'b0;
    clr_flush  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          state_next = WRITE;
        end else if (accept_ok) begin
          bypass     = 1'b1;
          state_next = WRITE;
        end else if (flush_pending_reg) begin
          state_next = DONE;
        end
      end
      WRITE: begin
        if (!master_waitrequest) begin
          if (!fifo_empty) begin
            pop = 1'b1;
          end else if (flush_pending_reg) begin
            state_next = DONE;
          end else begin
            state_next = IDLE;
          end
        end
      end
      DONE: begin
        clr_flush  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg         <= IDLE;
      wr_ptr_reg        <= '0;
      rd_ptr_reg        <= '0;
      count_reg         <= '0;
      flush_pending_reg <= 1'b0;
      drop_count_reg    <= '0;
      addr_reg          <= '0;
      data_reg          <= '0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_reg + CNT_W'(push) - CNT_W'(pop);
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;

      if (pop) begin
        addr_reg <= head[57:32];
        data_reg <= head[31:0];
      end else if (bypass) begin
        addr_reg <= pix_addr;
        data_reg <= pix_color;
      end

      // DONE clears the flag. A flush that arrives while one is pending
      // is absorbed, so only one flush_done is produced.
      if (clr_flush) begin
        flush_pending_reg <= 1'b0;
      end else if (flush) begin
        flush_pending_reg <= 1'b1;
      end

      if (accept && !in_range && drop_count_reg != 16'hFFFF) begin
        drop_count_reg <= drop_count_reg + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_reg] <= {pix_addr, pix_color};
  end

  assign master_write     = (state_reg == WRITE);
  assign master_address   = addr_reg;
  assign master_writedata = data_reg;
  assign flush_done       = (state_reg == DONE);
  assign busy             = (state_reg != IDLE) || !fifo_empty || flush_pending_reg;
  assign drop_count       = drop_count_reg;

endmodule

// File: tb/tb_fb_pixel_writer.sv
// Testbench for fb_pixel_writer. A single process drives the stimulus and
// samples the DUT once per cycle on the falling edge. A queue of expected
// writes is built from the address formula at each accepted in-range pixel.
module tb_fb_pixel_writer;
  localparam int H_RES = 640;
  localparam int V_RES = 480;

  logic        clk = 1'b0;
  logic        reset;
  logic [25:0] frame_buffer_ptr;
  logic        pix_valid;
  logic        pix_ready;
  logic [9:0]  pix_x;
  logic [8:0]  pix_y;
  logic [31:0] pix_color;
  logic        flush;
  logic        flush_done;
  logic        busy;
  logic [15:0] drop_count;
  logic [25:0] master_address;
  logic        master_write;
  logic [31:0] master_writedata;
  logic        master_waitrequest;

  always #5 clk = ~clk;

  fb_pixel_writer #(.H_RES(H_RES), .V_RES(V_RES), .FIFO_DEPTH(8)) dut (
    .clk                (clk),
    .reset              (reset),
    .frame_buffer_ptr   (frame_buffer_ptr),
    .pix_valid          (pix_valid),
    .pix_ready          (pix_ready),
    .pix_x              (pix_x),
    .pix_y              (pix_y),
    .pix_color          (pix_color),
    .flush              (flush),
    .flush_done         (flush_done),
    .busy               (busy),
    .drop_count         (drop_count),
    .master_address     (master_address),
    .master_write       (master_write),
    .master_writedata   (master_writedata),
    .master_waitrequest (master_waitrequest)
  );

  // Reference model and monitor state
  logic [57:0] exp_q[$];
  int          n_checks = 0;
  int          n_pass = 0;
  int          cyc = 0;
  int          writes = 0;
  int          mw_cycles = 0;
  int          fd_count = 0;
  int          fd_cyc = 0;
  int          last_wr_cyc = 0;
  int          acc_cyc = 0;
  int          mw_start_cyc = 0;
  int          nready_seen = 0;
  int          model_drop = 0;
  int          stall_left = 0;
  bit          prev_stall = 0;
  bit          prev_mw = 0;
  bit          last_accept = 0;
  bit          rand_wr = 0;
  logic [25:0] prev_addr;
  logic [31:0] prev_data;
  logic [25:0] last_addr;

  function automatic logic [25:0] model_addr(input logic [25:0] ptr, input int x, input int y);
    logic [63:0] a;
    a = 64'(ptr) + 64'((y * H_RES + x) * 4);
    return a[25:0];
  endfunction

  // One clock cycle: sample on the falling edge, then return 1 time unit after
  // the next rising edge with waitrequest set for the coming cycle.
  task automatic tick();
    logic [57:0] e;
    @(negedge clk);
    last_accept = 0;
    if (!reset) begin
      exp_q.delete();
      prev_stall = 0;
      prev_mw = 0;
      model_drop = 0;
    end else begin
      if (prev_stall) begin
        n_checks++;
        if (master_address !== prev_addr || master_writedata !== prev_data)
          $display("FAIL stall_stable: addr=%h data=%h, required addr=%h data=%h",
                   master_address, master_writedata, prev_addr, prev_data);
        else n_pass++;
      end
      if (master_write && !prev_mw) mw_start_cyc = cyc;
      if (master_write) mw_cycles++;
      if (master_write && !master_waitrequest) begin
        writes++;
        last_wr_cyc = cyc;
        last_addr = master_address;
        n_checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL write_order: unexpected write addr=%h data=%h, required no write",
                   master_address, master_writedata);
        end else begin
          e = exp_q.pop_front();
          if ({master_address, master_writedata} !== e)
            $display("FAIL write_order: addr=%h data=%h, required addr=%h data=%h",
                     master_address, master_writedata, e[57:32], e[31:0]);
          else n_pass++;
        end
      end
      prev_stall = master_write && master_waitrequest;
      prev_mw = master_write;
      prev_addr = master_address;
      prev_data = master_writedata;
      if (pix_valid && pix_ready) begin
        last_accept = 1;
        acc_cyc = cyc;
        if (int'(pix_x) < H_RES && int'(pix_y) < V_RES)
          exp_q.push_back({model_addr(frame_buffer_ptr, int'(pix_x), int'(pix_y)), pix_color});
        else if (model_drop < 65535)
          model_drop++;
      end else if (pix_valid) begin
        nready_seen++;
      end
      if (flush_done) begin
        fd_count++;
        fd_cyc = cyc;
      end
    end
    cyc++;
    @(posedge clk);
    #1;
    if (rand_wr) master_waitrequest = 1'($urandom_range(0, 1));
    else if (stall_left > 0) begin
      master_waitrequest = 1'b1;
      stall_left--;
    end else master_waitrequest = 1'b0;
  endtask

  task automatic push_pixel(input int x, input int y, input logic [31:0] c);
    bit ok;
    ok = 0;
    pix_x = 10'(x);
    pix_y = 9'(y);
    pix_color = c;
    pix_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (last_accept) begin
        ok = 1;
        break;
      end
    end
    pix_valid = 1'b0;
    n_checks++;
    if (!ok) $display("FAIL push_accept: pixel (%0d,%0d) not accepted, required accepted", x, y);
    else n_pass++;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 0;
    for (int i = 0; i < 500; i++) begin
      if (!busy && exp_q.size() == 0) begin
        ok = 1;
        break;
      end
      tick();
    end
    n_checks++;
    if (!ok) $display("FAIL drain: busy=%0b pending_writes=%0d, required 0/0", busy, exp_q.size());
    else n_pass++;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    frame_buffer_ptr = '0;
    pix_valid = 1'b0;
    pix_x = '0;
    pix_y = '0;
    pix_color = '0;
    flush = 1'b0;
    master_waitrequest = 1'b0;
    repeat (3) tick();
    n_checks++;
    if (pix_ready !== 1'b1) $display("FAIL reset_ready: got %b, required 1", pix_ready);
    else n_pass++;
    n_checks++;
    if ({master_write, flush_done, busy} !== 3'b000)
      $display("FAIL reset_flags: write/done/busy=%b, required 000", {master_write, flush_done, busy});
    else n_pass++;
    n_checks++;
    if (drop_count !== 16'd0 || master_address !== 26'd0 || master_writedata !== 32'd0)
      $display("FAIL reset_values: drop=%h addr=%h data=%h, required 0",
               drop_count, master_address, master_writedata);
    else n_pass++;
    reset = 1'b1;
    tick();
  endtask

  task automatic test_single();
    int w0, m0;
    rand_wr = 0;
    frame_buffer_ptr = 26'h100000;
    w0 = writes;
    m0 = mw_cycles;
    push_pixel(3, 2, 32'hFF00AA55);
    repeat (6) tick();
    n_checks++;
    if (writes - w0 != 1) $display("FAIL single_writes: got %0d, required 1", writes - w0);
    else n_pass++;
    n_checks++;
    if (mw_cycles - m0 != 1) $display("FAIL single_write_len: got %0d cycles, required 1", mw_cycles - m0);
    else n_pass++;
    n_checks++;
    // 0x100000 + (2*640 + 3) * 4
    if (last_addr !== 26'h10140C) $display("FAIL single_addr: got %h, required 10140c", last_addr);
    else n_pass++;
    n_checks++;
    if (mw_start_cyc - acc_cyc != 1)
      $display("FAIL single_latency: got %0d, required 1", mw_start_cyc - acc_cyc);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int w0, n0;
    rand_wr = 0;
    w0 = writes;
    n0 = nready_seen;
    frame_buffer_ptr = 26'($urandom);
    master_waitrequest = 1'b1;
    stall_left = 11;
    for (int i = 0; i < 10; i++)
      push_pixel($urandom_range(0, H_RES - 1), $urandom_range(0, V_RES - 1), $urandom);
    wait_idle();
    n_checks++;
    if (nready_seen == n0) $display("FAIL b2b_full: pix_ready never dropped, required drop when full");
    else n_pass++;
    n_checks++;
    if (writes - w0 != 10) $display("FAIL b2b_writes: got %0d, required 10", writes - w0);
    else n_pass++;
  endtask

  task automatic test_drops();
    int w0, m0;
    w0 = writes;
    m0 = mw_cycles;
    push_pixel(640, 0, $urandom);
    push_pixel(0, 480, $urandom);
    repeat (5) tick();
    n_checks++;
    if (writes != w0 || mw_cycles != m0)
      $display("FAIL drop_nowrite: writes=%0d active=%0d, required 0/0", writes - w0, mw_cycles - m0);
    else n_pass++;
    n_checks++;
    if (drop_count !== 16'd2) $display("FAIL drop_count: got %0d, required 2", drop_count);
    else n_pass++;
  endtask

  task automatic test_flush_pixels();
    int fd0, leak;
    bit acc3;
    rand_wr = 1;
    fd0 = fd_count;
    leak = 0;
    acc3 = 0;
    push_pixel($urandom_range(0, H_RES - 1), $urandom_range(0, V_RES - 1), $urandom);
    push_pixel($urandom_range(0, H_RES - 1), $urandom_range(0, V_RES - 1), $urandom);
    pix_x = 10'($urandom_range(0, H_RES - 1));
    pix_y = 9'($urandom_range(0, V_RES - 1));
    pix_color = $urandom;
    pix_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (pix_ready) begin
        flush = 1'b1;
        tick();
        acc3 = last_accept;
        break;
      end
      tick();
    end
    flush = 1'b0;
    pix_valid = 1'b0;
    // A second pulse while pending must not produce a second flush_done.
    flush = 1'b1;
    tick();
    flush = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (fd_count > fd0) break;
      if (pix_ready) leak++;
      tick();
    end
    n_checks++;
    if (!acc3) $display("FAIL flush_same_cycle: pixel not accepted with flush, required accepted");
    else n_pass++;
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL flush_complete: %0d writes outstanding at done, required 0", exp_q.size());
    else n_pass++;
    n_checks++;
    if (leak != 0) $display("FAIL flush_ready: ready high %0d cycles while pending, required 0", leak);
    else n_pass++;
    n_checks++;
    if (fd_cyc - last_wr_cyc != 1)
      $display("FAIL flush_timing: done %0d cycles after last write, required 1", fd_cyc - last_wr_cyc);
    else n_pass++;
    rand_wr = 0;
    repeat (4) tick();
    n_checks++;
    if (fd_count - fd0 != 1) $display("FAIL flush_once: got %0d pulses, required 1", fd_count - fd0);
    else n_pass++;
  endtask

  task automatic test_flush_idle();
    int fd0, fcyc;
    wait_idle();
    fd0 = fd_count;
    fcyc = cyc;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n_checks++;
    if (busy !== 1'b1) $display("FAIL flush_idle_busy1: got %b, required 1", busy);
    else n_pass++;
    tick();
    n_checks++;
    if (busy !== 1'b1) $display("FAIL flush_idle_busy2: got %b, required 1", busy);
    else n_pass++;
    repeat (3) tick();
    n_checks++;
    if (fd_count - fd0 != 1 || fd_cyc - fcyc != 2)
      $display("FAIL flush_idle_done: pulses=%0d delay=%0d, required 1/2", fd_count - fd0, fd_cyc - fcyc);
    else n_pass++;
  endtask

  task automatic test_random();
    rand_wr = 1;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) frame_buffer_ptr = 26'($urandom);
      if ($urandom_range(0, 2) == 0) tick();
      push_pixel($urandom_range(0, 700), $urandom_range(0, 511), $urandom);
    end
    rand_wr = 0;
    wait_idle();
    n_checks++;
    if (int'(drop_count) != model_drop) $display("FAIL random_drops: got %0d, required %0d", drop_count, model_drop);
    else n_pass++;
  endtask

  task automatic test_reset_midwrite();
    int w0;
    bit seen;
    rand_wr = 0;
    master_waitrequest = 1'b1;
    stall_left = 1000;
    seen = 0;
    push_pixel(10, 10, $urandom);
    push_pixel(11, 10, $urandom);
    push_pixel(12, 10, $urandom);
    for (int i = 0; i < 20; i++) begin
      if (master_write) begin
        seen = 1;
        break;
      end
      tick();
    end
    n_checks++;
    if (!seen) $display("FAIL rst_mid_setup: master_write never high, required high");
    else n_pass++;
    #2;
    reset = 1'b0;
    #1;
    n_checks++;
    if (master_write !== 1'b0) $display("FAIL rst_async: master_write=%b, required 0", master_write);
    else n_pass++;
    tick();
    stall_left = 0;
    master_waitrequest = 1'b0;
    tick();
    reset = 1'b1;
    w0 = writes;
    repeat (5) tick();
    n_checks++;
    if (busy !== 1'b0 || pix_ready !== 1'b1 || master_write !== 1'b0)
      $display("FAIL rst_after: busy=%b ready=%b write=%b, required 0/1/0", busy, pix_ready, master_write);
    else n_pass++;
    n_checks++;
    if (writes != w0 || drop_count !== 16'd0)
      $display("FAIL rst_flushed: writes=%0d drop=%0d, required 0/0", writes - w0, drop_count);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_drops();
    test_flush_pixels();
    test_flush_idle();
    test_random();
    test_reset_midwrite();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
